// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus-cycle engine and the upstream sequencing FSMs:
// bus-cycle state encoding, default phase timings and RTC register map.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_A_SETUP  = 3'd1,
    ST_A_STROBE = 3'd2,
    ST_A_HOLD   = 3'd3,
    ST_D_SETUP  = 3'd4,
    ST_D_STROBE = 3'd5,
    ST_D_HOLD   = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  localparam int DEF_T_SETUP = 2;
  localparam int DEF_T_PULSE = 4;
  localparam int DEF_T_HOLD  = 2;

  // RTC register map, shared with the init and read/write control FSMs
  localparam logic [7:0] REG_SECONDS    = 8'h21;
  localparam logic [7:0] REG_MINUTES    = 8'h22;
  localparam logic [7:0] REG_HOURS      = 8'h23;
  localparam logic [7:0] REG_DAY        = 8'h24;
  localparam logic [7:0] REG_MONTH      = 8'h25;
  localparam logic [7:0] REG_YEAR       = 8'h26;
  localparam logic [7:0] REG_TIMER_LO   = 8'h27;
  localparam logic [7:0] REG_TIMER_HI   = 8'h28;
  localparam logic [7:0] REG_CMD_STATUS = 8'h2F;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter that times one bus-cycle phase; zero marks the last cycle
// of the phase when loaded with (length - 1) on phase entry.
module rtc_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rtc_bus_cycle.sv
// Two-phase (address, then data) transaction engine for the RTC multiplexed AD bus.
// Every pin is registered from the next-state decode, so strobes never glitch.
module rtc_bus_cycle
  import rtc_pkg::*;
#(
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_PULSE = DEF_T_PULSE,
  parameter int T_HOLD  = DEF_T_HOLD,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output state_t     state
);

  // Handshake: start is the request valid and !busy is ready; a request transfers
  // on the clock edge where start && !busy, and its fields are latched there.

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);

  state_t           state_d;
  logic             rw_q, rw_n, accept;
  logic [7:0]       addr_q, addr_n, wdata_q, wdata_n;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic             addr_ph, data_ph, cap;
  logic             a_d_d, ad_oe_d, cs_d, rd_d, wr_d, busy_d, done_d;
  logic [7:0]       ad_out_d;

  rtc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE:     if (start)    begin state_d = ST_A_SETUP;  tmr_load = 1'b1; tmr_val = LD_SETUP; end
      ST_A_SETUP:  if (tmr_zero) begin state_d = ST_A_STROBE; tmr_load = 1'b1; tmr_val = LD_PULSE; end
      ST_A_STROBE: if (tmr_zero) begin state_d = ST_A_HOLD;   tmr_load = 1'b1; tmr_val = LD_HOLD;  end
      ST_A_HOLD:   if (tmr_zero) begin state_d = ST_D_SETUP;  tmr_load = 1'b1; tmr_val = LD_SETUP; end
      ST_D_SETUP:  if (tmr_zero) begin state_d = ST_D_STROBE; tmr_load = 1'b1; tmr_val = LD_PULSE; end
      ST_D_STROBE: if (tmr_zero) begin state_d = ST_D_HOLD;   tmr_load = 1'b1; tmr_val = LD_HOLD;  end
      ST_D_HOLD:   if (tmr_zero) state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Decode pins from the state being entered, using the request fields it will hold
  always_comb begin
    accept  = (state == ST_IDLE) && start;
    rw_n    = accept ? rw    : rw_q;
    addr_n  = accept ? addr  : addr_q;
    wdata_n = accept ? wdata : wdata_q;
    addr_ph = (state_d == ST_A_SETUP) || (state_d == ST_A_STROBE) || (state_d == ST_A_HOLD);
    data_ph = (state_d == ST_D_SETUP) || (state_d == ST_D_STROBE) || (state_d == ST_D_HOLD);
    a_d_d    = !addr_ph;
    ad_oe_d  = addr_ph || (data_ph && !rw_n);
    ad_out_d = addr_ph ? addr_n : ((data_ph && !rw_n) ? wdata_n : 8'h00);
    cs_d     = !((state_d == ST_A_STROBE) || (state_d == ST_D_STROBE));
    wr_d     = !((state_d == ST_A_STROBE) || ((state_d == ST_D_STROBE) && !rw_n));
    rd_d     = !((state_d == ST_D_STROBE) && rw_n);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    cap      = (state == ST_D_STROBE) && (state_d != ST_D_STROBE) && rw_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      rw_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      a_d     <= 1'b1;
      cs      <= 1'b1;
      rd      <= 1'b1;
      wr      <= 1'b1;
      ad_oe   <= 1'b0;
      ad_out  <= 8'h00;
      rdata   <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      rw_q    <= rw_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      a_d     <= a_d_d;
      cs      <= cs_d;
      rd      <= rd_d;
      wr      <= wr_d;
      ad_oe   <= ad_oe_d;
      ad_out  <= ad_out_d;
      busy    <= busy_d;
      done    <= done_d;
      if (cap) rdata <= ad_in;
    end
  end

endmodule
